can_tx_framer: RTL and testbench

CAN_TX_FRAMER -- requirements
Module: can_tx_framer

---
 rtl/can_tx_framer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_can_tx_framer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_framer.sv
// rtl/can_tx_framer.sv - CAN 2.0A/2.0B transmit framer with bit timing, CRC-15 and bit stuffing
//
// Purpose: serialises one standard or extended data/remote frame per accepted
// rising edge of startXmit onto canTx, with per-bit timing
// sync + propQuanta + seg1Quanta + PHASE_SEG2 quanta. Each quantum is
// quantaDiv+1 clocks.
//
// Parameters:
//   PHASE_SEG2 - phase segment 2 length in quanta (1..8)
//   IFS_BITS   - intermission length in bit times
//
// Ports:
//   HCLK        in   clock, rising edge
//   HRESETn     in   asynchronous active-low reset
//   startXmit   in   transmit request (rising edge accepted in IDLE)
//   quantaDiv   in   [7:0]  prescaler, quantum = quantaDiv+1 clocks
//   propQuanta  in   [5:0]  propagation segment in quanta
//   seg1Quanta  in   [5:0]  phase segment 1 in quanta
//   xmitdata    in   [63:0] payload, byte 0 = [63:56]
//   datalen     in   [3:0]  DLC (sent raw, payload bytes = min(DLC,8))
//   id          in   [28:0] identifier, base = [28:18], extension = [17:0]
//   format      in   0 = standard, 1 = extended
//   frameType   in   [1:0]  00 = data, 01 = remote, 1x = rejected
//   busy        out  frame in progress
//   canTx       out  serial bus output, 1 = recessive
//   canRx       in   bus readback (used only for the ACK slot)
//   ackErr      out  1-cycle pulse on return to IDLE when ACK slot read recessive
//   fmtErr      out  1-cycle pulse when a request is rejected
//
// Configuration: define CAN_TX_ACK_CHECK_EN to enable ACK-slot checking;
// otherwise canRx is ignored and ackErr is tied to 0.
module can_tx_framer #(
  parameter int PHASE_SEG2 = 4,
  parameter int IFS_BITS   = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        startXmit,
  input  logic [7:0]  quantaDiv,
  input  logic [5:0]  propQuanta,
  input  logic [5:0]  seg1Quanta,
  input  logic [63:0] xmitdata,
  input  logic [3:0]  datalen,
  input  logic [28:0] id,
  input  logic        format,
  input  logic [1:0]  frameType,
  output logic        busy,
  output logic        canTx,
  input  logic        canRx,
  output logic        ackErr,
  output logic        fmtErr
);

  localparam logic [7:0] PS2_Q    = 8'(PHASE_SEG2);
  localparam logic [6:0] IFS_LAST = 7'(IFS_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRCDEL, S_ACK, S_ACKDEL, S_EOF, S_IFS
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_start_q;
  logic [7:0]  r_qdiv;
  logic [5:0]  r_prop, r_seg1;
  logic [31:0] r_arb;
  logic [4:0]  r_arb_last;
  logic [5:0]  r_ctrl;
  logic [63:0] r_data;
  logic [6:0]  r_data_last;
  logic        r_has_data;
  logic [7:0]  r_qcnt, r_tq;
  logic [6:0]  r_cnt;
  logic        r_cantx;
  logic        r_stuff;
  logic [2:0]  r_run_cnt;
  logic        r_run_last;
  logic [14:0] r_crc;
  logic        r_fmterr;

  logic        w_edge, w_accept, w_reject;
  logic        w_qtick, w_bit_end;
  logic [7:0]  w_bit_tq;
  logic [3:0]  w_nbytes;
  logic [6:0]  w_field_last, w_adv_cnt, w_tgt_cnt;
  state_t      w_adv_state, w_tgt_state;
  logic        w_tgt_bit;
  logic        w_crc_zone, w_stuff_zone, w_crc_fb;
  logic [14:0] w_crc_upd;
  logic [2:0]  w_run_cnt_nxt;
  logic        w_need_stuff;

  assign w_edge   = startXmit & ~r_start_q;
  assign w_accept = w_edge && (r_state == S_IDLE) && !frameType[1];
  assign w_reject = w_edge && (r_state == S_IDLE) && frameType[1];
  assign w_nbytes = (datalen > 4'd8) ? 4'd8 : datalen;

  assign w_bit_tq  = 8'd1 + {2'b00, r_prop} + {2'b00, r_seg1} + PS2_Q;
  assign w_qtick   = (r_qcnt == r_qdiv);
  assign w_bit_end = w_qtick && (r_tq == w_bit_tq - 8'd1) && (r_state != S_IDLE);

  assign w_crc_zone   = (r_state == S_SOF) || (r_state == S_ARB) ||
                        (r_state == S_CTRL) || (r_state == S_DATA);
  assign w_stuff_zone = w_crc_zone || (r_state == S_CRC);

  // Last bit index of the field currently being sent.
  always_comb begin
    w_field_last = 7'd0;
    case (r_state)
      S_ARB:   w_field_last = {2'b00, r_arb_last};
      S_CTRL:  w_field_last = 7'd5;
      S_DATA:  w_field_last = r_data_last;
      S_CRC:   w_field_last = 7'd14;
      S_EOF:   w_field_last = 7'd6;
      S_IFS:   w_field_last = IFS_LAST;
      default: w_field_last = 7'd0;
    endcase
  end

  // Field position after the current data bit.
  always_comb begin
    w_adv_state = r_state;
    w_adv_cnt   = r_cnt + 7'd1;
    if (r_cnt == w_field_last) begin
      w_adv_cnt = 7'd0;
      case (r_state)
        S_SOF:    w_adv_state = S_ARB;
        S_ARB:    w_adv_state = S_CTRL;
        S_CTRL:   w_adv_state = r_has_data ? S_DATA : S_CRC;
        S_DATA:   w_adv_state = S_CRC;
        S_CRC:    w_adv_state = S_CRCDEL;
        S_CRCDEL: w_adv_state = S_ACK;
        S_ACK:    w_adv_state = S_ACKDEL;
        S_ACKDEL: w_adv_state = S_EOF;
        S_EOF:    w_adv_state = S_IFS;
        default:  w_adv_state = S_IDLE;
      endcase
    end
  end

  // A stuff bit is sent after the field position has already advanced, so
  // when it ends the position stays put and that position's bit goes out.
  assign w_tgt_state = r_stuff ? r_state : w_adv_state;
  assign w_tgt_cnt   = r_stuff ? r_cnt   : w_adv_cnt;

  // CRC including the data bit now ending (stuff bits are excluded).
  always_comb begin
    w_crc_fb  = r_cantx ^ r_crc[14];
    w_crc_upd = r_crc;
    if (!r_stuff && w_crc_zone)
      w_crc_upd = {r_crc[13:0], 1'b0} ^ (w_crc_fb ? 15'h4599 : 15'h0000);
  end

  always_comb begin
    w_tgt_bit = 1'b1;
    case (w_tgt_state)
      S_SOF:   w_tgt_bit = 1'b0;
      S_ARB:   w_tgt_bit = r_arb[5'd31 - w_tgt_cnt[4:0]];
      S_CTRL:  w_tgt_bit = r_ctrl[3'd5 - w_tgt_cnt[2:0]];
      S_DATA:  w_tgt_bit = r_data[6'd63 - w_tgt_cnt[5:0]];
      S_CRC:   w_tgt_bit = w_crc_upd[4'd14 - w_tgt_cnt[3:0]];
      default: w_tgt_bit = 1'b1;
    endcase
  end

  assign w_run_cnt_nxt = ((r_run_cnt != 3'd0) && (r_cantx == r_run_last)) ?
                         r_run_cnt + 3'd1 : 3'd1;
  assign w_need_stuff  = !r_stuff && w_stuff_zone && (w_run_cnt_nxt == 3'd5);

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_IDLE) begin
      if (w_accept) w_state_nxt = S_SOF;
    end else if (w_bit_end) begin
      w_state_nxt = w_tgt_state;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

`ifdef CAN_TX_ACK_CHECK_EN
  logic r_ack_miss, r_ackerr;
  logic w_sample;
  assign w_sample = w_qtick && (r_tq == {2'b00, r_prop} + {2'b00, r_seg1});

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ack_miss <= 1'b0;
      r_ackerr   <= 1'b0;
    end else begin
      r_ackerr <= 1'b0;
      if (w_accept)
        r_ack_miss <= 1'b0;
      else if ((r_state == S_ACK) && w_sample)
        r_ack_miss <= canRx;
      if (w_bit_end && !r_stuff && (w_adv_state == S_IDLE))
        r_ackerr <= r_ack_miss;
    end
  end
  assign ackErr = r_ackerr;
`else
  logic w_unused_rx;
  assign w_unused_rx = canRx;
  assign ackErr      = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_start_q   <= 1'b0;
      r_qdiv      <= '0;
      r_prop      <= '0;
      r_seg1      <= '0;
      r_arb       <= '0;
      r_arb_last  <= '0;
      r_ctrl      <= '0;
      r_data      <= '0;
      r_data_last <= '0;
      r_has_data  <= 1'b0;
      r_qcnt      <= '0;
      r_tq        <= '0;
      r_cnt       <= '0;
      r_cantx     <= 1'b1;
      r_stuff     <= 1'b0;
      r_run_cnt   <= '0;
      r_run_last  <= 1'b0;
      r_crc       <= '0;
      r_fmterr    <= 1'b0;
    end else begin
      r_start_q <= startXmit;
      r_fmterr  <= w_reject;
      if (w_accept) begin
        r_qdiv <= quantaDiv;
        r_prop <= propQuanta;
        r_seg1 <= seg1Quanta;
        if (format) begin
          r_arb      <= {id[28:18], 1'b1, 1'b1, id[17:0], frameType[0]};
          r_arb_last <= 5'd31;
        end else begin
          r_arb      <= {id[28:18], frameType[0], 20'd0};
          r_arb_last <= 5'd11;
        end
        // IDE,r0 (standard) and r1,r0 (extended) are both dominant.
        r_ctrl      <= {2'b00, datalen};
        r_data      <= xmitdata;
        r_data_last <= {w_nbytes, 3'b000} - 7'd1;
        r_has_data  <= !frameType[0] && (datalen != 4'd0);
        r_qcnt      <= '0;
        r_tq        <= '0;
        r_cnt       <= '0;
        r_cantx     <= 1'b0;
        r_stuff     <= 1'b0;
        r_run_cnt   <= '0;
        r_run_last  <= 1'b0;
        r_crc       <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_qtick) begin
          r_qcnt <= '0;
          r_tq   <= (r_tq == w_bit_tq - 8'd1) ? 8'd0 : r_tq + 8'd1;
        end else begin
          r_qcnt <= r_qcnt + 8'd1;
        end
        if (w_bit_end) begin
          r_cnt      <= w_tgt_cnt;
          r_crc      <= w_crc_upd;
          r_run_last <= r_cantx;
          if (r_stuff) begin
            r_stuff   <= 1'b0;
            r_run_cnt <= 3'd1;
            r_cantx   <= w_tgt_bit;
          end else begin
            r_run_cnt <= w_run_cnt_nxt;
            if (w_need_stuff) begin
              r_stuff <= 1'b1;
              r_cantx <= ~r_cantx;
            end else begin
              r_cantx <= w_tgt_bit;
            end
          end
        end
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign canTx  = r_cantx;
  assign fmtErr = r_fmterr;

endmodule

// File: tb/tb_can_tx_framer.sv
// tb/tb_can_tx_framer.sv - directed self-checking bench for can_tx_framer
module tb_can_tx_framer;

  localparam int IFS = 3;
`ifdef CAN_TX_ACK_CHECK_EN
  localparam int ACK_EXP = 1;
`else
  localparam int ACK_EXP = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        startXmit;
  logic [7:0]  quantaDiv;
  logic [5:0]  propQuanta;
  logic [5:0]  seg1Quanta;
  logic [63:0] xmitdata;
  logic [3:0]  datalen;
  logic [28:0] id;
  logic        format;
  logic [1:0]  frameType;
  logic        busy;
  logic        canTx;
  logic        canRx;
  logic        ackErr;
  logic        fmtErr;

  int n_cmp = 0;
  int n_bad = 0;

  bit          exp_q[$];
  int          umap[$];
  logic [14:0] exp_crc;
  bit          obs[0:1023];
  int          bc, br, ap;

  can_tx_framer #(.PHASE_SEG2(4), .IFS_BITS(IFS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .startXmit(startXmit),
    .quantaDiv(quantaDiv), .propQuanta(propQuanta), .seg1Quanta(seg1Quanta),
    .xmitdata(xmitdata), .datalen(datalen), .id(id), .format(format),
    .frameType(frameType), .busy(busy), .canTx(canTx), .canRx(canRx),
    .ackErr(ackErr), .fmtErr(fmtErr)
  );

  always #5 HCLK = ~HCLK;

  // Golden frame: unstuffed field list, CRC-15 over SOF..data, then stuffing
  // through the CRC end and a recessive tail.
  task automatic prep(input bit ext, input logic [1:0] ft, input logic [28:0] fid,
                      input logic [3:0] dlc, input logic [63:0] d);
    bit u[$];
    logic [14:0] crc;
    int nb, run;
    bit last, fb;
    format = ext; frameType = ft; id = fid; datalen = dlc; xmitdata = d;
    quantaDiv = 8'd0; propQuanta = 6'd1; seg1Quanta = 6'd2;
    u = {};
    u.push_back(1'b0);
    for (int i = 28; i >= 18; i--) u.push_back(fid[i]);
    if (ext) begin
      u.push_back(1'b1); u.push_back(1'b1);
      for (int i = 17; i >= 0; i--) u.push_back(fid[i]);
      u.push_back(ft[0]); u.push_back(1'b0); u.push_back(1'b0);
    end else begin
      u.push_back(ft[0]); u.push_back(1'b0); u.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    nb = ft[0] ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) u.push_back(d[63 - i]);
    crc = 15'd0;
    foreach (u[k]) begin
      fb = u[k] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
    exp_crc = crc;
    exp_q = {}; umap = {}; run = 0; last = 1'b0;
    foreach (u[k]) begin
      umap.push_back(exp_q.size());
      exp_q.push_back(u[k]);
      if (run != 0 && u[k] == last) run++;
      else begin run = 1; last = u[k]; end
      if (run == 5) begin exp_q.push_back(!last); last = !last; run = 1; end
    end
    for (int i = 0; i < 10 + IFS; i++) exp_q.push_back(1'b1);
  endtask

  function automatic int pattern_errs();
    int n = 0;
    for (int k = 0; k < exp_q.size(); k++) if (obs[k] !== exp_q[k]) n++;
    return n;
  endfunction

  function automatic logic [14:0] obs_crc();
    logic [14:0] r;
    int cs;
    cs = umap.size() - 15;
    for (int i = 0; i < 15; i++) r[14 - i] = obs[umap[cs + i]];
    return r;
  endfunction

  // Launches a frame and records canTx at each bit's 4th clock (8-clock bits).
  task automatic run_frame(input int window, input int hold, input int retrig, input bit give_ack);
    int ack_idx;
    bit prev_busy;
    ack_idx = exp_q.size() - (IFS + 9);
    @(negedge HCLK); startXmit = 1'b1;
    @(posedge HCLK); #1;
    bc = 0; br = 0; ap = 0; prev_busy = 1'b0;
    for (int c = 0; c < window; c++) begin
      canRx = (give_ack && (c / 8) == ack_idx) ? 1'b0 : 1'b1;
      if (c == 2) begin id = ~id; xmitdata = ~xmitdata; datalen = ~datalen; format = ~format; end
      if (c == hold) startXmit = 1'b0;
      if (c == retrig) startXmit = 1'b1;
      if (busy) bc++;
      if (busy && !prev_busy) br++;
      prev_busy = busy;
      if (ackErr) ap++;
      if ((c % 8) == 3 && (c / 8) < 1024) obs[c / 8] = canTx;
      @(posedge HCLK); #1;
    end
    startXmit = 1'b0; canRx = 1'b1;
    repeat (4) @(posedge HCLK);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; startXmit = 1'b0; canRx = 1'b1;
    prep(0, 2'b00, 29'd0, 4'd0, 64'd0);
    repeat (3) @(posedge HCLK); #1;
    n_cmp++; if (canTx !== 1'b1) begin n_bad++; $display("FAIL reset_canTx: got %b expected 1", canTx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (ackErr !== 1'b0) begin n_bad++; $display("FAIL reset_ackErr: got %b expected 0", ackErr); end
    n_cmp++; if (fmtErr !== 1'b0) begin n_bad++; $display("FAIL reset_fmtErr: got %b expected 0", fmtErr); end
    @(negedge HCLK); HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
  endtask

  task automatic test_std_remote();
    int e;
    logic [6:0] head;
    prep(0, 2'b01, {11'h7FF, 18'h0}, 4'd0, 64'd0);
    run_frame(exp_q.size() * 8 + 40, 0, -1, 1'b1);
    for (int i = 0; i < 7; i++) head[6 - i] = obs[i];
    e = pattern_errs();
    n_cmp++; if (head !== 7'b0111110) begin n_bad++; $display("FAIL remote_head: got %b expected 0111110", head); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL remote_pattern: got %0d bad bits expected 0", e); end
    n_cmp++; if (bc !== exp_q.size() * 8) begin n_bad++; $display("FAIL remote_busy_len: got %0d expected %0d", bc, exp_q.size() * 8); end
    n_cmp++; if (ap !== 0) begin n_bad++; $display("FAIL remote_ackErr: got %0d pulses expected 0", ap); end
  endtask

  task automatic test_std_data_stuff();
    int e;
    logic [5:0] head;
    prep(0, 2'b00, 29'd0, 4'd1, {8'hA5, 56'd0});
    run_frame(exp_q.size() * 8 + 40, 0, -1, 1'b1);
    for (int i = 0; i < 6; i++) head[5 - i] = obs[i];
    e = pattern_errs();
    n_cmp++; if (head !== 6'b000001) begin n_bad++; $display("FAIL std_stuff_idx5: got %b expected 000001", head); end
    n_cmp++; if (obs_crc() !== exp_crc) begin n_bad++; $display("FAIL std_crc: got %h expected %h", obs_crc(), exp_crc); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL std_pattern: got %0d bad bits expected 0", e); end
    n_cmp++; if (bc !== exp_q.size() * 8) begin n_bad++; $display("FAIL std_busy_len: got %0d expected %0d", bc, exp_q.size() * 8); end
  endtask

  task automatic test_ext_data();
    int e;
    prep(1, 2'b00, 29'h1ABCDEF1, 4'd8, 64'h0123456789ABCDEF);
    run_frame(exp_q.size() * 8 + 40, 0, -1, 1'b1);
    e = pattern_errs();
    n_cmp++; if (obs[umap[12]] !== 1'b1) begin n_bad++; $display("FAIL ext_srr: got %b expected 1", obs[umap[12]]); end
    n_cmp++; if (obs[umap[13]] !== 1'b1) begin n_bad++; $display("FAIL ext_ide: got %b expected 1", obs[umap[13]]); end
    n_cmp++; if (obs_crc() !== exp_crc) begin n_bad++; $display("FAIL ext_crc: got %h expected %h", obs_crc(), exp_crc); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL ext_pattern: got %0d bad bits expected 0", e); end
    n_cmp++; if (bc !== exp_q.size() * 8) begin n_bad++; $display("FAIL ext_busy_len: got %0d expected %0d", bc, exp_q.size() * 8); end
  endtask

  task automatic test_dlc12_hold();
    int e;
    logic [3:0] f;
    prep(0, 2'b00, {11'h2A5, 18'h0}, 4'd12, 64'hFEDCBA9876543210);
    run_frame(2100, 2000, -1, 1'b1);
    for (int i = 0; i < 4; i++) f[3 - i] = obs[umap[15 + i]];
    e = pattern_errs();
    n_cmp++; if (f !== 4'b1100) begin n_bad++; $display("FAIL dlc12_field: got %b expected 1100", f); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL dlc12_pattern: got %0d bad bits expected 0", e); end
    n_cmp++; if (br !== 1) begin n_bad++; $display("FAIL hold_frames: got %0d expected 1", br); end
    n_cmp++; if (bc !== exp_q.size() * 8) begin n_bad++; $display("FAIL dlc12_busy_len: got %0d expected %0d", bc, exp_q.size() * 8); end
  endtask

  task automatic test_fmt_err();
    int viol;
    prep(0, 2'b10, 29'd0, 4'd1, 64'd0);
    @(negedge HCLK); startXmit = 1'b1;
    @(posedge HCLK); #1;
    n_cmp++; if (fmtErr !== 1'b1) begin n_bad++; $display("FAIL fmt_pulse: got %b expected 1", fmtErr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fmt_busy: got %b expected 0", busy); end
    @(posedge HCLK); #1;
    n_cmp++; if (fmtErr !== 1'b0) begin n_bad++; $display("FAIL fmt_pulse_end: got %b expected 0", fmtErr); end
    viol = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy !== 1'b0 || canTx !== 1'b1 || fmtErr !== 1'b0) viol++;
      @(posedge HCLK); #1;
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL fmt_no_frame: got %0d bad cycles expected 0", viol); end
    startXmit = 1'b0;
    repeat (3) @(posedge HCLK);
  endtask

  task automatic test_ack_err();
    int e;
    prep(0, 2'b00, {11'h155, 18'h0}, 4'd2, {16'h3C00, 48'd0});
    run_frame(exp_q.size() * 8 + 40, 2, 100, 1'b0);
    e = pattern_errs();
    n_cmp++; if (ap !== ACK_EXP) begin n_bad++; $display("FAIL ack_err_pulses: got %0d expected %0d", ap, ACK_EXP); end
    n_cmp++; if (br !== 1) begin n_bad++; $display("FAIL busy_retrigger: got %0d frames expected 1", br); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL ack_pattern: got %0d bad bits expected 0", e); end
  endtask

  task automatic test_reset_mid_frame();
    int k, viol, e;
    prep(0, 2'b00, {11'h123, 18'h0}, 4'd8, 64'd0);
    k = -1;
    for (int i = umap[40]; i < umap[80]; i++) if (k < 0 && exp_q[i] == 1'b0) k = i;
    @(negedge HCLK); startXmit = 1'b1;
    @(posedge HCLK); #1;
    repeat (8 * k + 3) @(posedge HCLK);
    #4;
    n_cmp++; if (canTx !== exp_q[k]) begin n_bad++; $display("FAIL mid_before_reset: got %b expected %b", canTx, exp_q[k]); end
    HRESETn = 1'b0;
    #1;
    n_cmp++; if (canTx !== 1'b1) begin n_bad++; $display("FAIL mid_reset_canTx: got %b expected 1", canTx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    startXmit = 1'b0;
    @(negedge HCLK); @(negedge HCLK); HRESETn = 1'b1;
    viol = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge HCLK); #1;
      if (canTx !== 1'b1 || busy !== 1'b0) viol++;
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL post_reset_quiet: got %0d bad cycles expected 0", viol); end
    prep(0, 2'b00, {11'h0F0, 18'h0}, 4'd1, {8'h0F, 56'd0});
    run_frame(exp_q.size() * 8 + 40, 0, -1, 1'b1);
    e = pattern_errs();
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL post_reset_pattern: got %0d bad bits expected 0", e); end
  endtask

  initial begin
    test_reset();
    test_std_remote();
    test_std_data_stuff();
    test_ext_data();
    test_dlc12_hold();
    test_fmt_err();
    test_ack_err();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
